// File: rtl/shift_ctrl.sv
// Sequencer around an external combinational 16-bit shifter: native SLL/SRL in
// one pass, SRA/ROL as two passes whose results are OR-merged in an accumulator.
module shift_ctrl #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [AMT_W-1:0]  req_amount,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [AMT_W-1:0]  sh_amount,
  output logic [DATA_W-1:0] sh_data,
  output logic              sh_lorr,
  input  logic [DATA_W-1:0] sh_result,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and ready is a pure state decode.

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        op_q;
  logic [AMT_W-1:0]  amt_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] acc;
  logic              accept;

  assign accept    = req_valid && req_ready;
  assign rsp_data  = acc;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      amt_q  <= '0;
      data_q <= '0;
      acc    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= req_op;
        amt_q  <= req_amount;
        data_q <= req_data;
        // A zero shift bypasses the shifter entirely.
        if (req_amount == '0) acc <= req_data;
      end
      if (state == PASS1) acc <= sh_result;
      if (state == PASS2) acc <= acc | sh_result;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    sh_amount = '0;
    sh_data   = '0;
    sh_lorr   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (accept) state_nxt = (req_amount == '0) ? DONE : PASS1;
      end
      PASS1: begin
        sh_data   = data_q;
        sh_amount = amt_q;
        sh_lorr   = (op_q == OP_SRL) || (op_q == OP_SRA);
        state_nxt = (op_q == OP_SRA || op_q == OP_ROL) ? PASS2 : DONE;
      end
      PASS2: begin
        // DATA_W == 2**AMT_W, so the wrapped negation is DATA_W - amt_q.
        sh_amount = '0 - amt_q;
        if (op_q == OP_ROL) begin
          sh_data = data_q;
          sh_lorr = 1'b1;
        end else begin
          sh_data = {DATA_W{data_q[DATA_W-1]}};
          sh_lorr = 1'b0;
        end
        state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed and random bench for shift_ctrl with a behavioural shifter model,
// latency checks and an expected-result queue.
module tb_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_amount;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        busy;
  logic [3:0]  sh_amount;
  logic [15:0] sh_data;
  logic        sh_lorr;
  logic [15:0] sh_result;
  logic [1:0]  dbg_state;

  logic [15:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // External combinational shifter.
  assign sh_result = sh_lorr ? (sh_data >> sh_amount) : (sh_data << sh_amount);

  shift_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_amount(req_amount), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .sh_amount(sh_amount), .sh_data(sh_data), .sh_lorr(sh_lorr),
    .sh_result(sh_result), .dbg_state(dbg_state)
  );

  function automatic logic [15:0] model(input logic [1:0] op, input logic [3:0] a,
                                        input logic [15:0] d);
    logic [15:0] r;
    case (op)
      2'b00: r = d << a;
      2'b01: r = d >> a;
      2'b10: r = 16'($signed(d) >>> a);
      default: r = (a == 4'd0) ? d : ((d << a) | (d >> (16 - int'(a))));
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [1:0] op, input logic [3:0] a);
    if (a == 4'd0) return 1;
    return op[1] ? 3 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sh_zero(input string tag);
    chk(tag, {15'd0, sh_lorr, sh_amount, sh_data}, 32'd0);
  endtask

  // Drives one request at a negedge, pushes its expected result, returns at the
  // negedge after the accept edge.
  task automatic do_req(input logic [1:0] op, input logic [3:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_op     = op;
    req_amount = a;
    req_data   = d;
    exp_q.push_back(model(op, a, d));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until rsp_valid, checks data, optionally
  // holds rsp_ready low for `hold` cycles while pushing an ignored request.
  task automatic wait_rsp(input int exp_lat, input int hold, input bit sh_zero);
    int lat = 1;
    logic [15:0] exp;
    while (!rsp_valid && lat < 20) begin
      if (sh_zero) chk_sh_zero("sh_zero_busy");
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("queue_nonempty", exp_q.size() != 0, 1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    chk("rsp_data", rsp_data, exp);
    if (sh_zero) chk_sh_zero("sh_zero_done");
    for (int i = 0; i < hold; i++) begin
      req_valid  = 1'b1;
      req_op     = 2'($urandom_range(0, 3));
      req_amount = 4'($urandom_range(0, 15));
      req_data   = 16'($urandom_range(0, 16'hFFFF));
      @(posedge clk);
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_data", rsp_data, exp);
      chk("hold_busy", busy, 1);
      chk("hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [15:0] d,
                        input logic [15:0] lit);
    chk("model_literal", model(op, a, d), lit);
    do_req(op, a, d);
    wait_rsp(lat_of(op, a), 0, a == 4'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_amount = 4'd0;
    req_data   = 16'd0;
    rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_state", dbg_state, 2'd0);
    chk_sh_zero("rst_sh");
    rst_n = 1'b1;

    run_op(2'b00, 4'd4,  16'h00F1, 16'h0F10);
    run_op(2'b10, 4'd3,  16'h8000, 16'hF000);
    run_op(2'b10, 4'd3,  16'h4000, 16'h0800);
    run_op(2'b11, 4'd1,  16'h8001, 16'h0003);
    run_op(2'b11, 4'd15, 16'h1234, 16'h091A);
    for (int op = 0; op < 4; op++) run_op(2'(op), 4'd0, 16'hBEEF, 16'hBEEF);

    // Backpressure with an ignored second request.
    do_req(2'b01, 4'd15, 16'hFFFF);
    wait_rsp(2, 5, 1'b0);

    // Reset during PASS2 of a ROL discards the operation.
    do_req(2'b11, 4'd5, 16'h1234);
    chk("pass1_sh_data", sh_data, 16'h1234);
    chk("pass1_sh_amount", sh_amount, 4'd5);
    chk("pass1_sh_lorr", sh_lorr, 0);
    @(posedge clk);
    @(negedge clk);
    chk("pass2_sh_amount", sh_amount, 4'd11);
    chk("pass2_sh_lorr", sh_lorr, 1);
    chk("pass2_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_rsp_data", rsp_data, 16'h0000);
    chk_sh_zero("midrst_sh");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_no_rsp", rsp_valid, 0);
    run_op(2'b11, 4'd4, 16'hA5C3, 16'h5C3A);

    for (int i = 0; i < 10; i++) begin
      logic [1:0]  op;
      logic [3:0]  a;
      logic [15:0] d;
      op = 2'($urandom_range(0, 3));
      a  = 4'($urandom_range(0, 15));
      d  = 16'($urandom_range(0, 16'hFFFF));
      do_req(op, a, d);
      wait_rsp(lat_of(op, a), int'($urandom_range(0, 2)), a == 4'd0);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
